clock_divider: RTL and testbench
================================

# clock_divider

Programmable integer clock divider that derives a slower clock from a reference clock by a runtime-selectable ratio. It feeds baud/sample clocks to the serial and peripheral blocks in the system. Even ratios give a 50% duty cycle; odd ratios give a low phase one reference cycle longer than the high phase. An enable input and ratios 0/1 select a bypass path that passes the reference clock straight through.

## Interface
Parameters:
- ratio_width, default 8: width of the division-ratio input and of the internal counters.

Ports:
- i_ref_clk  input  1  reference clock; all state updates on its rising edge.
- i_rst  input  1  reset; one clock, reset is synchronous and active-high.
- i_clk_en  input  1  1 = divider active, 0 = bypass.
- i_div_ratio  input  ratio_width  division ratio N, unsigned.
- o_div_clk  output  1  divided (or bypassed) clock.

## Operation
- Mode select (combinational): divide mode when i_clk_en=1 and i_div_ratio ≥ 2. Otherwise bypass, and o_div_clk = i_ref_clk.
- In divide mode, o_div_clk = internal output register div_q.
- State:
  - div_q (1 bit).
  - Phase counter cnt (ratio_width bits).
  - Latched ratio n_q (ratio_width bits).
- Reset (i_rst=1 at a rising edge): div_q=0, cnt=0, n_q=0.
  - While reset is active, o_div_clk follows the mode-select rule.
  - In divide mode during reset, o_div_clk is therefore 0.
- In bypass mode (not in reset), each edge sets div_q=0, cnt=0 and n_q=i_div_ratio. The next divide period therefore starts cleanly.
- Phase lengths, counted in reference cycles:
  - Even N: low = high = N/2.
  - Odd N: low = (N+1)/2, high = (N−1)/2.
- Divide-mode edge behaviour:
  - cnt increments every edge.
  - When cnt = current phase length − 1, div_q toggles and cnt returns to 0.
- Ratio latching: n_q loads i_div_ratio only at the edge where div_q toggles 1→0 (end of a full period), and on every bypass edge. Ratio changes therefore take effect only at period boundaries, with no runt pulses in divide mode.
- Phase lengths are computed from n_q, not from i_div_ratio directly.
  - If n_q < 2 while in divide mode (first edge after leaving bypass with a freshly latched ratio), the lengths use i_div_ratio instead.
- Arithmetic: halves are n_q>>1, and odd low phase = (n_q>>1)+1. No overflow is possible for N ≤ 2^ratio_width − 1.
- Mode switch between bypass and divide is a combinational mux. A glitch at the switch instant is permitted.

## Timing
- Latency: once divide mode holds and reset is released, div_q first rises after (low phase length) rising edges of i_ref_clk.
- Period in divide mode is exactly N reference cycles. All transitions of o_div_clk occur just after a rising edge of i_ref_clk.
- A reset asserted mid-period takes effect at the next rising edge:
  - o_div_clk goes to 0 in divide mode.
  - The period restarts from the beginning after release.
- Changing i_div_ratio mid-period does not alter the current period. The new ratio applies from the next period start.
- Deasserting i_clk_en or setting N to 0/1 switches to bypass immediately (combinational). Re-entering divide mode starts with a full low phase.
- Simultaneous reset and mode change: reset wins for state; output still follows the mode mux.

## Test plan
- Bypass cases, each with reset released:
  - i_clk_en=0, N=6 -> o_div_clk identical to i_ref_clk.
  - i_clk_en=1, N=0 -> identical to i_ref_clk.
  - i_clk_en=1, N=1 -> identical to i_ref_clk.
- Reset, enable=1, N=2, release reset -> o_div_clk period 2 reference cycles, 1 low / 1 high, first rise 1 edge after release.
- Reset, N=4, release -> period 4, 2 low / 2 high. Repeat with N=8 -> 4 low / 4 high, period 8.
- Reset, N=5, release -> period 5, low 3 cycles / high 2 cycles, for at least two periods.
- Running N=4, change to N=6 mid-high-phase -> current period completes as 4. The next periods are 6 (3/3) with no short pulse.
- Divide mode N=8, assert i_rst for 2 cycles mid-high-phase -> o_div_clk 0 from the next edge. After release, a full 4-cycle low phase, then normal 4/4 operation.

Source files
------------

// File: rtl/clock_divider.sv
// clock_divider
//
// Purpose: programmable integer clock divider. Derives a slower clock from
// the reference clock by a runtime-selectable ratio N. Even ratios give a 50%
// duty cycle. Odd ratios give a low phase one reference cycle longer than the
// high phase. When the divider is disabled, or N is 0 or 1, the reference
// clock is passed straight through.
//
// Ports:
//   i_ref_clk    - reference clock; all state updates on its rising edge
//   i_rst        - synchronous active-high reset
//   i_clk_en     - 1 = divider active, 0 = bypass
//   i_div_ratio  - division ratio N (unsigned, ratio_width bits)
//   o_div_clk    - divided (or bypassed) clock
module clock_divider #(
  parameter int ratio_width = 8
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_clk_en,
  input  logic [ratio_width-1:0] i_div_ratio,
  output logic                   o_div_clk
);

  logic                   div_q, div_d;
  logic [ratio_width-1:0] cnt_q, cnt_d;
  logic [ratio_width-1:0] n_q, n_d;

  logic                   divide_mode;
  logic [ratio_width-1:0] eff_n;
  logic [ratio_width-1:0] half_len;
  logic [ratio_width-1:0] low_len;
  logic [ratio_width-1:0] phase_len;
  logic                   phase_end;

  // Divide mode only for an enabled divider with a real ratio (N >= 2).
  assign divide_mode = i_clk_en && (i_div_ratio >= ratio_width'(2));

  // The latched ratio is held at 0 by reset, so the first period after reset
  // takes its phase lengths from the live input instead.
  assign eff_n     = (n_q < ratio_width'(2)) ? i_div_ratio : n_q;
  assign half_len  = eff_n >> 1;
  // Odd ratios put the extra cycle into the low phase.
  assign low_len   = half_len + {{(ratio_width-1){1'b0}}, eff_n[0]};
  assign phase_len = div_q ? half_len : low_len;
  assign phase_end = (cnt_q == (phase_len - ratio_width'(1)));

  // Next-state logic. Bypass keeps the divider parked at the start of a low
  // phase with the current ratio latched. In divide mode the ratio is only
  // re-latched when the high phase ends, so a ratio change never shortens the
  // period in progress.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    n_d   = n_q;
    if (!divide_mode) begin
      div_d = 1'b0;
      cnt_d = '0;
      n_d   = i_div_ratio;
    end else if (phase_end) begin
      div_d = ~div_q;
      cnt_d = '0;
      if (div_q) begin
        n_d = i_div_ratio;
      end
    end else begin
      cnt_d = cnt_q + ratio_width'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      div_q <= 1'b0;
      cnt_q <= '0;
      n_q   <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      n_q   <= n_d;
    end
  end

  // Combinational mode mux; a glitch at the switch instant is acceptable.
  assign o_div_clk = divide_mode ? div_q : i_ref_clk;

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider
//
// Purpose: self-checking bench for clock_divider. A table of vectors covers
// the bypass cases and several divide ratios; hand-written sequences cover a
// mid-period ratio change, a mid-period reset and bypass exit/entry.
// Expected output bits are pushed to a queue as each edge is driven and
// popped when the output is sampled.
module tb_clock_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] ratio;
  logic         div_clk;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  typedef struct {
    logic         en;
    logic [W-1:0] ratio;
    bit           bypass;
    int           low;
    int           cycles;
  } vec_t;

  vec_t vecs[9];

  clock_divider #(.ratio_width(W)) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
    .o_div_clk  (div_clk)
  );

  // 10-unit reference clock period.
  always #5 clk = ~clk;

  // Expected divided output k edges after the period start: the first 'low'
  // cycles of each N-cycle period are low, the rest high.
  function automatic bit divExp(input int k, input int n, input int low);
    return (k % n) >= low;
  endfunction

  // Pop the oldest expected value and compare it with the DUT output.
  task automatic checkOutput(input string name);
    bit e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s: scoreboard empty, o_div_clk=%b", name, div_clk);
      return;
    end
    e = exp_q.pop_front();
    if (div_clk !== e) begin
      fails++;
      $display("[TB] FAIL %s: o_div_clk=%b expected %b at t=%0t", name, div_clk, e, $time);
    end
  endtask

  // One reset edge with the given mode inputs, released just after the edge.
  task automatic doReset(input logic e, input logic [W-1:0] r);
    rst   = 1'b1;
    en    = e;
    ratio = r;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Bypass: output must track the reference clock level in both halves.
  task automatic checkBypass(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #2;
      exp_q.push_back(1'b1);
      checkOutput(name);
      @(negedge clk);
      #2;
      exp_q.push_back(1'b0);
      checkOutput(name);
    end
  endtask

  // Apply one table vector from reset and follow it for v.cycles edges.
  task automatic applyStimulus(input vec_t v, input string name);
    doReset(v.en, v.ratio);
    if (v.bypass) begin
      checkBypass(v.cycles, name);
    end else begin
      for (int k = 0; k < v.cycles; k++) begin
        if (k > 0) @(posedge clk);
        exp_q.push_back(divExp(k, int'(v.ratio), v.low));
        @(negedge clk);
        checkOutput(name);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    ratio = 8'd4;

    vecs[0] = '{en: 1'b0, ratio: 8'd6,   bypass: 1'b1, low: 0,   cycles: 4};
    vecs[1] = '{en: 1'b1, ratio: 8'd0,   bypass: 1'b1, low: 0,   cycles: 4};
    vecs[2] = '{en: 1'b1, ratio: 8'd1,   bypass: 1'b1, low: 0,   cycles: 4};
    vecs[3] = '{en: 1'b1, ratio: 8'd2,   bypass: 1'b0, low: 1,   cycles: 8};
    vecs[4] = '{en: 1'b1, ratio: 8'd4,   bypass: 1'b0, low: 2,   cycles: 12};
    vecs[5] = '{en: 1'b1, ratio: 8'd8,   bypass: 1'b0, low: 4,   cycles: 24};
    vecs[6] = '{en: 1'b1, ratio: 8'd5,   bypass: 1'b0, low: 3,   cycles: 16};
    vecs[7] = '{en: 1'b1, ratio: 8'd3,   bypass: 1'b0, low: 2,   cycles: 10};
    vecs[8] = '{en: 1'b1, ratio: 8'd255, bypass: 1'b0, low: 128, cycles: 520};

    // Reset state in divide mode: output held low during reset.
    repeat (2) @(posedge clk);
    exp_q.push_back(1'b0);
    @(negedge clk);
    checkOutput("reset_state");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d_n%0d", i, vecs[i].ratio));
    end

    // Ratio change 4 -> 6 in the high phase of the second period: that period
    // still lasts 4, then 3/3 periods follow.
    doReset(1'b1, 8'd4);
    for (int k = 0; k <= 26; k++) begin
      if (k > 0) @(posedge clk);
      exp_q.push_back((k < 8) ? divExp(k, 4, 2) : divExp(k - 8, 6, 3));
      @(negedge clk);
      checkOutput("ratio_change");
      if (k == 6) ratio = 8'd6;
    end

    // Reset held for two edges in the high phase of N=8, then a clean restart.
    doReset(1'b1, 8'd8);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(posedge clk);
      exp_q.push_back(divExp(k, 8, 4));
      @(negedge clk);
      checkOutput("pre_reset");
    end
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      exp_q.push_back(1'b0);
      @(negedge clk);
      checkOutput("mid_reset");
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      exp_q.push_back(divExp(k, 8, 4));
      @(negedge clk);
      checkOutput("post_reset");
    end

    // Now in a high phase (k=20). Dropping enable bypasses immediately.
    en    = 1'b0;
    ratio = 8'd4;
    #1;
    exp_q.push_back(1'b0);
    checkOutput("bypass_immediate");
    checkBypass(3, "bypass_hold");

    // Re-entering divide mode starts with a full low phase at the latched N=4.
    @(negedge clk);
    en = 1'b1;
    #1;
    exp_q.push_back(1'b0);
    checkOutput("reenter");
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      exp_q.push_back(divExp(k, 4, 2));
      @(negedge clk);
      checkOutput("reenter_run");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
